truth_table_sweeper: RTL and testbench

Synthesizable exhaustive stimulus driver and response checker for small combinational gates such as the 2-input NOR. On `start` it walks every input vector from 0 to 2^N_IN-1 on `stim`. For each vector it waits a programmable settle time, then samples the gate output on `resp` and compares it against a parameterised expected truth table. It replaces hand-written per-gate initial-block sweeps with one reusable self-checking block that produces training-data captures.

---
 rtl/sweep_pkg.sv | 18 +
 rtl/sweep_settle_timer.sv | 38 +++
 rtl/truth_table_sweeper.sv | 147 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and constants for the truth-table sweeper
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [3:0] NOR2_TABLE = 4'b0001;
  localparam logic [3:0] AND2_TABLE = 4'b1000;
  localparam logic [3:0] OR2_TABLE  = 4'b1110;

  // Settle timer width: covers the full 0..15 settle range.
  localparam int TIMER_W = $clog2(16);

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - loadable down-counter timing the settle window
module sweep_settle_timer
  import sweep_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expired means the current cycle is the last settle cycle, so the
  // owner can move to its sampling step on this edge.
  assign expired = (count_q <= TIMER_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive stimulus driver and response checker
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                N_IN   = 2,
  parameter int                SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECT = NOR2_TABLE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_IN-1:0]     stim,
  input  logic                resp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_count,
  output logic [N_IN-1:0]     first_fail,
  output logic                fail_seen,
  output logic [2**N_IN-1:0]  observed
);

  localparam logic [N_IN-1:0]    LAST_IDX = '1;
  localparam logic [N_IN:0]      ERR_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN-1:0]    IDX_ONE  = N_IN'(1);
  localparam logic [TIMER_W-1:0] SETTLE_V = TIMER_W'(SETTLE);
  // With no settle time the sample step directly follows the stim update.
  localparam state_e AFTER_DRIVE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N_IN:0]       err_count_q, err_count_d;
  logic [N_IN-1:0]     first_fail_q, first_fail_d;
  logic                fail_seen_q, fail_seen_d;
  logic [2**N_IN-1:0]  observed_q, observed_d;

  logic timer_load;
  logic timer_expired;
  logic mismatch;

  sweep_settle_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (SETTLE_V),
    .expired (timer_expired)
  );

  // Compare the response against the expected table; an unknown response
  // fails the equality test and therefore counts as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (resp == EXPECT[idx_q]) begin
      mismatch = 1'b0;
    end
  end

  // Sweep sequencing, index advance and scoreboard update.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    observed_d   = observed_q;
    timer_load   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = AFTER_DRIVE;
          idx_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          err_count_d  = '0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
          observed_d   = '0;
          timer_load   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        observed_d[idx_q] = resp;
        if (mismatch) begin
          err_count_d = err_count_q + ERR_ONE;
          if (!fail_seen_q) begin
            first_fail_d = idx_q;
            fail_seen_d  = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d    = AFTER_DRIVE;
          idx_d      = idx_q + IDX_ONE;
          timer_load = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep and zeroes outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      observed_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      observed_q   <= observed_d;
    end
  end

  assign stim       = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_count_q == '0);
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign fail_seen  = fail_seen_q;
  assign observed   = observed_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for the sweeper
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start0;
  logic [1:0] mode;  // 0: NOR gate, 1: OR gate, 2: output stuck at 0

  logic [1:0] stim, stim0;
  logic       resp, resp0;
  logic       busy, busy0, done, done0, pass, pass0;
  logic [2:0] err_count, err_count0;
  logic [1:0] first_fail, first_fail0;
  logic       fail_seen, fail_seen0;
  logic [3:0] observed, observed0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign resp  = (mode == 2'd0) ? ~|stim  : (mode == 2'd1) ? |stim  : 1'b0;
  assign resp0 = (mode == 2'd0) ? ~|stim0 : (mode == 2'd1) ? |stim0 : 1'b0;

  truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0001)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .resp(resp),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .fail_seen(fail_seen), .observed(observed)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(0), .EXPECT(4'b0001)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .stim(stim0), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .first_fail(first_fail0), .fail_seen(fail_seen0), .observed(observed0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start across one rising edge (edge 0); returns 1 time unit after it.
  task automatic go();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, done, 1);
  endtask

  task automatic check_results(input string tag, input logic [3:0] obs_exp,
                               input logic [2:0] err_exp, input logic [1:0] ff_exp,
                               input logic fs_exp, input logic pass_exp);
    chk({tag, "_observed"}, observed, obs_exp);
    chk({tag, "_err_count"}, err_count, err_exp);
    chk({tag, "_first_fail"}, first_fail, ff_exp);
    chk({tag, "_fail_seen"}, fail_seen, fs_exp);
    chk({tag, "_pass"}, pass, pass_exp);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;
    mode   = 2'd0;
    #12;
    chk("reset_stim", stim, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_observed", observed, 0);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: NOR gate, cycle-accurate stim/busy/done timing.
    go();
    chk("s1_e0_stim", stim, 0);
    chk("s1_e0_busy", busy, 1);
    chk("s1_e0_done", done, 0);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("s1_e%0d_stim", e), stim, (e < 8) ? e / 2 : 3);
      chk($sformatf("s1_e%0d_busy", e), busy, (e < 8) ? 1 : 0);
      chk($sformatf("s1_e%0d_done", e), done, (e == 8) ? 1 : 0);
    end
    check_results("s1", 4'b0001, 3'd0, 2'd0, 1'b0, 1'b1);

    // Scenario 2: OR gate against the NOR table.
    mode = 2'd1;
    go();
    chk("s2_start_clears_done", done, 0);
    chk("s2_start_clears_err", err_count, 0);
    wait_done("s2_done");
    check_results("s2", 4'b1110, 3'd4, 2'd0, 1'b1, 1'b0);

    // Scenario 3: output stuck at 0, then a clean NOR rerun from DONE.
    mode = 2'd2;
    go();
    wait_done("s3_done");
    check_results("s3", 4'b0000, 3'd1, 2'd0, 1'b1, 1'b0);
    mode = 2'd0;
    go();
    chk("s3r_clear_err", err_count, 0);
    chk("s3r_clear_fail_seen", fail_seen, 0);
    chk("s3r_clear_observed", observed, 0);
    chk("s3r_clear_done", done, 0);
    chk("s3r_clear_pass", pass, 0);
    wait_done("s3r_done");
    check_results("s3r", 4'b0001, 3'd0, 2'd0, 1'b0, 1'b1);

    // Scenario 4: zero settle time, sweep completes four edges after start.
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    chk("s4_e0_busy", busy0, 1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("s4_e%0d_done", e), done0, (e == 4) ? 1 : 0);
    end
    chk("s4_observed", observed0, 4'b0001);
    chk("s4_pass", pass0, 1);

    // Scenario 5: start pulses at edge 3 and at the last SAMPLE edge 8.
    go();
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      start = (e == 3 || e == 8) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e == 3) chk("s5_e3_stim", stim, 1);
    end
    chk("s5_e8_done", done, 1);
    @(posedge clk);
    #1;
    chk("s5_e9_done_held", done, 1);
    chk("s5_e9_stim_held", stim, 3);
    check_results("s5", 4'b0001, 3'd0, 2'd0, 1'b0, 1'b1);

    // Scenario 6: asynchronous reset mid-sweep, then a full fresh sweep.
    go();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("s6_stim_before_rst", stim, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_stim", stim, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_observed", observed, 0);
    chk("s6_rst_err_count", err_count, 0);
    chk("s6_rst_fail_seen", fail_seen, 0);
    @(negedge clk);
    rst = 1'b0;
    go();
    wait_done("s6_done");
    check_results("s6", 4'b0001, 3'd0, 2'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
